host_uart_frame_asm: RTL and testbench
======================================

Name: host_uart_frame_asm

Overview:
- Upstream neighbour of the host UART command decoder.
- Collects raw bytes from the UART receiver into length-prefixed frames and packs the payload LSB-first into a 1024-bit word.
- Presents that word to the decoder with a one-cycle start pulse, then holds it stable until the decoder reports done.
- Rejects malformed, oversize, timed-out and (optionally) corrupt frames before the decoder ever sees them.

Parameters:
- MAX_BYTES, 128, maximum payload bytes per frame; legal range 1..128 (1024/8).
- SOF_BYTE, 8'h7E, start-of-frame marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- dec_done  in  1  decoder done; ends the hold of the current frame.
- frame_data  out  1024  payload; byte i at bits [8i+7:8i], unused bytes zero.
- frame_len  out  8  payload byte count of the held frame.
- frame_start  out  1  one-cycle pulse to decoder start.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  one-cycle pulse: length 0 or >MAX_BYTES.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.
- err_overrun  out  1  one-cycle pulse: byte dropped while in ISSUE or WAIT_DONE.
- err_csum  out  1  one-cycle pulse: checksum mismatch (0 when feature absent).

Behaviour:
- Reset (reset=0, async): state IDLE; frame_data=0, frame_len=0; frame_start, busy and all err_* = 0; byte counter and timeout counter = 0.
- IDLE:
  - rx_valid with rx_data==SOF_BYTE -> LEN; clear frame_data to 0 on that cycle.
  - Any other byte is ignored silently.
- LEN:
  - Byte 0x00 or >MAX_BYTES -> err_len pulse, back to IDLE.
  - Otherwise latch frame_len, zero the byte index -> PAYLOAD.
- PAYLOAD:
  - Each valid byte is written to frame_data[8*idx +: 8] and idx increments.
  - On the byte where idx==frame_len-1 -> CSUM if the feature is present, else ISSUE.
  - A byte equal to SOF_BYTE inside the payload is data, never a resync.
- ISSUE:
  - frame_start=1 for exactly one cycle -> WAIT_DONE.
  - Latency: last accepted byte at cycle N, frame_start at cycle N+1.
- WAIT_DONE:
  - frame_data and frame_len are held constant.
  - dec_done=1 -> IDLE; the next frame may begin on the following cycle.
- Overrun: rx_valid in ISSUE or WAIT_DONE drops the byte and pulses err_overrun in the next cycle.
- Timeout:
  - Counter is active only in LEN, PAYLOAD and CSUM; it clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES-1 pulses err_timeout and returns to IDLE. frame_start is never issued for that frame.
- Simultaneous events:
  - Timeout expiry and rx_valid in the same cycle: the byte wins and the counter clears.
  - dec_done while not in WAIT_DONE is ignored.
- Reset mid-frame: frame discarded and all outputs forced to reset values immediately; no frame_start follows.

Optional Feature:
- Macro: HOST_FRAME_CSUM_EN.
- Defined:
  - A running XOR of the length byte and all payload bytes is kept.
  - After the last payload byte the state is CSUM, where one more byte is expected.
  - Match -> ISSUE. Mismatch -> err_csum pulse, IDLE, no frame_start.
  - Timeout applies in CSUM.
- Undefined: no CSUM state, no XOR register; err_csum tied 0.

Decomposition:
- Shared package host_uart_pkg:
  - SOF_BYTE default.
  - MAX_FRAME_BITS=1024.
  - State enum {IDLE, LEN, PAYLOAD, CSUM, ISSUE, WAIT_DONE}.
  - Error-bit index constants.
- Sub-module host_uart_frame_timeout: a loadable inter-byte timeout counter with clear, enable and expire outputs. Parameterised by TIMEOUT_CYCLES and reused later by the response encoder.

Test Plan:
- Bytes 7E 09 01 FF FF FF FF FF FF 01 01 (plus 08 if CSUM_EN) -> frame_start one cycle, frame_len=9, frame_data=72'h0101FFFFFFFFFFFF01 with upper bits 0. Hold until dec_done; busy drops the cycle after.
- Bytes 7E 07 03 27 FF 27 FF 27 FF (plus DC if CSUM_EN) -> frame_data=56'hFF27FF27FF2703, frame_len=7. Then send a second frame before dec_done -> err_overrun per byte, first frame unchanged.
- Bytes 7E 00, then 7E 81 -> err_len twice, no frame_start, busy=0.
- Bytes 7E 09 01 then silence for TIMEOUT_CYCLES (bench overrides to 50) -> err_timeout once, state IDLE. A following full valid frame is accepted.
- CSUM_EN: first frame with checksum 09 -> err_csum, no frame_start. Without CSUM_EN the same byte after the frame is ignored in IDLE.
- Assert reset for one cycle midway through the payload of the first frame -> all outputs 0 at once, no frame_start. A subsequent complete frame decodes correctly.

Source files
------------

// File: rtl/host_uart_pkg.sv
// Shared constants for the host UART framing path: SOF default,
// frame width, FSM state codes and error-bit indices.
package host_uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;
  localparam int MAX_FRAME_BITS = 1024;
  localparam int MAX_FRAME_BYTES = MAX_FRAME_BITS / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  localparam int ERR_LEN = 0;
  localparam int ERR_TIMEOUT = 1;
  localparam int ERR_OVERRUN = 2;
  localparam int ERR_CSUM = 3;
  localparam int ERR_W = 4;

endpackage

// File: rtl/host_uart_frame_timeout.sv
// Inter-byte idle counter: clear restarts it, enable lets it count,
// expire fires on the cycle the count sits at TIMEOUT_CYCLES-1.
// Ports: clk, reset (async low), clear, enable -> expire.
module host_uart_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // clear has priority, so a byte in the expiry cycle wins
  assign expire = enable & ~clear & (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/host_uart_frame_asm.sv
// Assembles SOF/length-prefixed UART bytes into a 1024-bit frame for
// the command decoder; start pulse, hold until dec_done, error pulses.
// Ports: clk, reset (async low), rx_data/rx_valid, dec_done in;
// frame_data/frame_len/frame_start, busy, err_* out.
// Macro HOST_FRAME_CSUM_EN adds a trailing XOR checksum byte.
module host_uart_frame_asm
  import host_uart_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      dec_done,
  output logic [MAX_FRAME_BITS-1:0] frame_data,
  output logic [7:0]                frame_len,
  output logic                      frame_start,
  output logic                      busy,
  output logic                      err_len,
  output logic                      err_timeout,
  output logic                      err_overrun,
  output logic                      err_csum
);

  localparam logic [7:0] MAXB = 8'(MAX_BYTES);

  logic [2:0] state;
  logic [6:0] idx;
  logic [ERR_W-1:0] err_q;
  logic active;
  logic expire;
  logic last;
  logic held;

`ifdef HOST_FRAME_CSUM_EN
  logic [7:0] csum;
`endif

  assign active = (state == S_LEN) || (state == S_PAYLOAD)
               || (state == S_CSUM);
  assign held = (state == S_ISSUE) || (state == S_WAIT_DONE);
  assign last = ({1'b0, idx} == frame_len - 8'd1);

  assign frame_start = (state == S_ISSUE);
  assign busy = (state != S_IDLE);
  assign err_len = err_q[ERR_LEN];
  assign err_timeout = err_q[ERR_TIMEOUT];
  assign err_overrun = err_q[ERR_OVERRUN];
`ifdef HOST_FRAME_CSUM_EN
  assign err_csum = err_q[ERR_CSUM];
`else
  assign err_csum = 1'b0;
`endif

  // any byte, or being outside a frame, restarts the idle count
  host_uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk(clk),
    .reset(reset),
    .clear(rx_valid | ~active),
    .enable(active),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx <= '0;
      err_q <= '0;
      frame_data <= '0;
      frame_len <= '0;
`ifdef HOST_FRAME_CSUM_EN
      csum <= '0;
`endif
    end else begin
      err_q <= '0;
      if (rx_valid && held) err_q[ERR_OVERRUN] <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SOF_BYTE) begin
            frame_data <= '0;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0 || rx_data > MAXB) begin
              err_q[ERR_LEN] <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_len <= rx_data;
              idx <= '0;
`ifdef HOST_FRAME_CSUM_EN
              csum <= rx_data;
`endif
              state <= S_PAYLOAD;
            end
          end else if (expire) begin
            err_q[ERR_TIMEOUT] <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            frame_data[{idx, 3'b000} +: 8] <= rx_data;
            idx <= idx + 7'd1;
`ifdef HOST_FRAME_CSUM_EN
            csum <= csum ^ rx_data;
            if (last) state <= S_CSUM;
`else
            if (last) state <= S_ISSUE;
`endif
          end else if (expire) begin
            err_q[ERR_TIMEOUT] <= 1'b1;
            state <= S_IDLE;
          end
        end
`ifdef HOST_FRAME_CSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state <= S_ISSUE;
            end else begin
              err_q[ERR_CSUM] <= 1'b1;
              state <= S_IDLE;
            end
          end else if (expire) begin
            err_q[ERR_TIMEOUT] <= 1'b1;
            state <= S_IDLE;
          end
        end
`endif
        S_ISSUE: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (dec_done) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_uart_frame_asm.sv
// Self-checking bench for host_uart_frame_asm: frame-level model
// compared every cycle plus hand-computed frame checks.
module tb_host_uart_frame_asm;

  localparam int T = 50;
  localparam int MAXB = 128;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic dec_done = 1'b0;
  logic [1023:0] frame_data;
  logic [7:0] frame_len;
  logic frame_start, busy;
  logic err_len, err_timeout, err_overrun, err_csum;

  host_uart_frame_asm #(
    .MAX_BYTES(MAXB),
    .SOF_BYTE(8'h7E),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .dec_done(dec_done),
    .frame_data(frame_data),
    .frame_len(frame_len),
    .frame_start(frame_start),
    .busy(busy),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_csum(err_csum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [1023:0] act,
                     input logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // frame-level model: a frame is SOF, length, payload bytes
  bit in_frame, have_len, csum_wait, holding, was_start, fin;
  int len, idle_cnt;
  logic [7:0] ck;
  logic [7:0] pay[$];
  logic [1023:0] e_data;
  logic [7:0] e_len;
  bit e_start, e_busy, e_el, e_et, e_eo, e_ec;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_frame = 0; have_len = 0; csum_wait = 0; holding = 0;
      idle_cnt = 0; len = 0; ck = 0; pay.delete();
      e_data = '0; e_len = 0; e_start = 0; e_busy = 0;
      e_el = 0; e_et = 0; e_eo = 0; e_ec = 0;
    end else begin
      was_start = e_start;
      e_start = 0; fin = 0;
      e_el = 0; e_et = 0; e_eo = 0; e_ec = 0;
      if (was_start || holding) begin
        if (rx_valid) e_eo = 1;
        if (was_start) holding = 1;
        else if (dec_done) holding = 0;
      end else if (!in_frame) begin
        if (rx_valid && rx_data == 8'h7E) begin
          in_frame = 1; have_len = 0; csum_wait = 0;
          idle_cnt = 0; e_data = '0;
        end
      end else if (rx_valid) begin
        idle_cnt = 0;
        if (!have_len) begin
          if (rx_data == 0 || int'(rx_data) > MAXB) begin
            e_el = 1; in_frame = 0;
          end else begin
            have_len = 1; len = int'(rx_data);
            e_len = rx_data; ck = rx_data; pay.delete();
          end
        end else if (csum_wait) begin
          if (rx_data == ck) fin = 1;
          else begin e_ec = 1; in_frame = 0; end
        end else begin
          e_data[8*pay.size() +: 8] = rx_data;
          pay.push_back(rx_data);
          ck = ck ^ rx_data;
          if (pay.size() == len) begin
`ifdef HOST_FRAME_CSUM_EN
            csum_wait = 1;
`else
            fin = 1;
`endif
          end
        end
      end else begin
        idle_cnt++;
        if (idle_cnt == T) begin e_et = 1; in_frame = 0; end
      end
      if (fin) begin in_frame = 0; csum_wait = 0; e_start = 1; end
      e_busy = in_frame || e_start || holding;
    end
  end

  int n_start = 0, n_el = 0, n_et = 0, n_eo = 0, n_ec = 0;

  always @(negedge clk) begin
    chk("frame_data", frame_data, e_data);
    chk("frame_len", frame_len, e_len);
    chk("frame_start", frame_start, e_start);
    chk("busy", busy, e_busy);
    chk("err_len", err_len, e_el);
    chk("err_timeout", err_timeout, e_et);
    chk("err_overrun", err_overrun, e_eo);
    chk("err_csum", err_csum, e_ec);
    n_start += int'(frame_start);
    n_el += int'(err_len);
    n_et += int'(err_timeout);
    n_eo += int'(err_overrun);
    n_ec += int'(err_csum);
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send(input bq_t q);
    foreach (q[i]) put(q[i]);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    rx_valid = 1'b0;
    dec_done = 1'b1;
    @(negedge clk);
    dec_done = 1'b0;
  endtask

  localparam logic [71:0] F1_DATA = 72'h0101FFFFFFFFFFFF01;
  localparam logic [55:0] F2_DATA = 56'hFF27FF27FF2703;

  bq_t f1, f2, f1bad;
  int exp_start;

  initial begin
    f1 = '{8'h7E, 8'h09, 8'h01, 8'hFF, 8'hFF, 8'hFF,
           8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
    f2 = '{8'h7E, 8'h07, 8'h03, 8'h27, 8'hFF, 8'h27,
           8'hFF, 8'h27, 8'hFF};
    f1bad = f1;
    f1bad.push_back(8'h09);
`ifdef HOST_FRAME_CSUM_EN
    f1.push_back(8'h08);
    f2.push_back(8'hDC);
`endif
    exp_start = 0;

    repeat (3) @(negedge clk);
    chk("rst_data", frame_data, '0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    gap(2);

    send(f1);
    gap(3);
    exp_start++;
    chk("f1_data", frame_data, {952'b0, F1_DATA});
    chk("f1_len", frame_len, 8'd9);
    chk("f1_starts", n_start, exp_start);
    chk("f1_busy_hold", busy, 1'b1);
    done_pulse();
    chk("f1_busy_drop", busy, 1'b0);
    gap(2);

    send(f2);
    gap(3);
    exp_start++;
    chk("f2_data", frame_data, {968'b0, F2_DATA});
    chk("f2_len", frame_len, 8'd7);
    send(f2);
    gap(2);
    chk("ovr_count", n_eo, f2.size());
    chk("ovr_data", frame_data, {968'b0, F2_DATA});
    chk("ovr_starts", n_start, exp_start);
    done_pulse();
    gap(2);

    put(8'h7E); put(8'h00); put(8'h7E); put(8'h81);
    gap(2);
    chk("len_errs", n_el, 2);
    chk("len_starts", n_start, exp_start);
    chk("len_busy", busy, 1'b0);

    put(8'h7E); put(8'h09); put(8'h01);
    gap(T + 5);
    chk("tmo_count", n_et, 1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_starts", n_start, exp_start);
    send(f1);
    gap(3);
    exp_start++;
    chk("tmo_f1_data", frame_data, {952'b0, F1_DATA});
    chk("tmo_f1_starts", n_start, exp_start);
    done_pulse();
    gap(2);

`ifdef HOST_FRAME_CSUM_EN
    send(f1bad);
    gap(3);
    chk("csum_errs", n_ec, 1);
`else
    send(f1bad);
    gap(3);
    exp_start++;
    done_pulse();
    put(8'h09);
    gap(3);
    chk("csum_errs", n_ec, 0);
`endif
    chk("csum_starts", n_start, exp_start);
    chk("csum_busy", busy, 1'b0);

    put(8'h7E); put(8'h09); put(8'h01); put(8'hFF); put(8'hFF);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_data", frame_data, '0);
    chk("mid_rst_len", frame_len, 8'd0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    gap(3);
    chk("mid_rst_starts", n_start, exp_start);
    send(f1);
    gap(3);
    exp_start++;
    chk("post_rst_data", frame_data, {952'b0, F1_DATA});
    chk("post_rst_len", frame_len, 8'd9);
    chk("post_rst_starts", n_start, exp_start);
    done_pulse();
    gap(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
